// File: rtl/inst_encoder_if.sv
// Field-set input and encoded-word output bundle of the instruction encoder.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready travel in the opposite direction to the data.
interface inst_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        opcode;
   logic [4:0]        rd, rn, rm;
   logic [4:0]        vd, vn, vm;
   logic [14:0]       imm15;
   logic [14:0]       vimm15;
   logic [24:0]       imm25;
   logic              out_valid;
   logic              out_ready;
   logic [32:0]       out_inst;
   logic [ADDR_W-1:0] out_addr;

   // Encoder side: consumes field sets, produces words.
   modport slave (
      input  in_valid, opcode, rd, rn, rm, vd, vn, vm, imm15, vimm15, imm25, out_ready,
      output in_ready, out_valid, out_inst, out_addr
   );

   // Producer/consumer side around the encoder.
   modport master (
      output in_valid, opcode, rd, rn, rm, vd, vn, vm, imm15, vimm15, imm25, out_ready,
      input  in_ready, out_valid, out_inst, out_addr
   );
endinterface

// File: rtl/inst_encoder.sv
// Packs opcode/operand field sets into 33-bit instruction words tagged with sequential addresses.
// Latency: 1 cycle from input acceptance to out_valid; 1 word/cycle with out_ready high.
// Backpressure: a single output register; in_ready drops while the held word is not taken.
// Optional: define INST_PARITY_EN to drive out_inst[32] with even parity over [31:0].
module inst_encoder #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              stop,
   inst_encoder_if.slave     bus,
   output logic              busy,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] FULL  = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [32:0]       enc;
   logic [4:0]        reg_d, reg_n, reg_m;
   logic [14:0]       imm_sel;
   logic [1:0]        cls;
   logic              vsel, form;
   logic              accept;
   logic              xfer;
   logic              addr_max;

   assign cls          = bus.opcode[6:5];
   assign vsel         = bus.opcode[4];
   assign form         = bus.opcode[3];
   assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign xfer         = bus.out_valid && bus.out_ready;
   assign addr_max     = (addr == {ADDR_W{1'b1}});
   assign busy         = (state != IDLE);

   // Field packing; class 11 always takes the scalar fields regardless of the vector select.
   always_comb begin
      reg_d   = vsel ? bus.vd : bus.rd;
      reg_n   = vsel ? bus.vn : bus.rn;
      reg_m   = vsel ? bus.vm : bus.rm;
      imm_sel = vsel ? bus.vimm15 : bus.imm15;
      enc     = '0;
      enc[31:25] = bus.opcode;
      case (cls)
         2'b00: begin
            if (!form) begin
               enc[14:0] = imm_sel;
            end else begin
               enc[24:20] = reg_d;
               enc[19:15] = reg_n;
               enc[14:10] = reg_m;
            end
         end
         2'b01: begin
            enc[24:20] = reg_d;
            enc[19:15] = reg_n;
            if (!form) enc[14:10] = reg_m;
            else       enc[14:0]  = imm_sel;
         end
         2'b10: begin
            enc[24:20] = reg_d;
            enc[19:15] = reg_n;
            enc[14:0]  = imm_sel;
         end
         default: begin
            if (!form) begin
               enc[24:20] = bus.rd;
               enc[19:15] = bus.rn;
               enc[14:0]  = bus.imm15;
            end else begin
               enc[24:0] = bus.imm25;
            end
         end
      endcase
`ifdef INST_PARITY_EN
      enc[32] = ^enc[31:0];
`else
      enc[32] = 1'b0;
`endif
   end

   // Program sequencing: stop wins over the full transition when both land in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state <= RUN;
            RUN: begin
               if (stop)                     state <= DRAIN;
               else if (accept && addr_max)  state <= FULL;
            end
            DRAIN,
            FULL:    if (!bus.out_valid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Address counter saturates at the top address and flags full instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr  <= '0;
         full  <= 1'b0;
         count <= '0;
      end else if (state == IDLE && start) begin
         addr  <= start_addr;
         full  <= 1'b0;
         count <= '0;
      end else begin
         if (accept) begin
            if (addr_max) full <= 1'b1;
            else          addr <= addr + 1'b1;
         end
         if (xfer) count <= count + 1'b1;
      end
   end

   // Output register holds the word and its address until downstream takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_inst  <= '0;
         bus.out_addr  <= '0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_inst  <= enc;
         bus.out_addr  <= addr;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule
